pc_sequencer: RTL
=================

# pc_sequencer

Sequential program-counter stage that sits directly downstream of the branch unit and consumes its next-PC-select decision. It holds the architectural PC and handshakes with instruction memory. Each time an instruction completes, it advances the PC to PC+4 or to the branch/jump target. It also detects misaligned targets and fetch timeouts, halting the core in either case, and counts retired instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- MAX_WAIT, 15, maximum consecutive unstalled cycles in FETCH with memory not ready before timeout; range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- PSNextPCSrc  in  1  from branch unit; 1 = take PSTarget, 0 = PC+4.
- PSTarget  in  32  branch/jump target computed by the ALU.
- PSStall  in  1  hold request; blocks commit and freezes the PC.
- PSIMemReady  in  1  instruction memory has valid data for PSPC.
- PSPC  out  32  current PC, registered.
- PSPCPlus4  out  32  combinational PSPC+4, mod 2^32, feeds the writeback for jal/jalr.
- PSFetchValid  out  1  combinational commit strobe for the instruction at PSPC.
- PSMisaligned  out  1  sticky flag, registered.
- PSTimeout  out  1  sticky flag, registered.
- PSRetired  out  32  retired-instruction counter, registered.

## Operation
- State machine states: RESET_HOLD, FETCH, HALT.
- RESET_HOLD:
  - Entered on reset.
  - Lasts exactly one clock after rst deasserts, then goes to FETCH unconditionally.
  - No commit in this state.
- FETCH, commit condition: commit = PSIMemReady and not PSStall. PSFetchValid = commit.
- Effective target is {PSTarget[31:1], 1'b0}; bit 0 is always cleared, per jalr semantics.
- On commit with PSNextPCSrc=1 and PSTarget[1]=1 (misaligned target):
  - PSPC is held.
  - PSMisaligned is set.
  - PSRetired is not incremented.
  - Next state is HALT.
- On any other commit:
  - PSPC loads the effective target if PSNextPCSrc=1, else PSPC+4.
  - PSRetired increments by 1 and wraps 32'hFFFF_FFFF to 0.
  - The wait counter clears.
- Wait counter (8-bit):
  - Clears on commit or whenever PSStall=1.
  - Increments on each FETCH cycle with PSStall=0 and PSIMemReady=0.
  - When it would reach MAX_WAIT, PSTimeout is set and the next state is HALT.
- Priority: PSStall overrides PSIMemReady. A stall never counts toward timeout.
- HALT:
  - Terminal state, left only by rst.
  - PSPC, PSRetired and the flags are frozen.
  - PSFetchValid = 0 regardless of inputs.
- PC+4 overflow: 32'hFFFF_FFFC + 4 = 0 (wrap, no flag).

## Timing
- Reset values:
  - PSPC = RESET_PC, so PSPCPlus4 = RESET_PC+4.
  - PSFetchValid = 0.
  - PSMisaligned = 0, PSTimeout = 0, PSRetired = 0.
  - Wait counter = 0, state = RESET_HOLD.
- Reset mid-operation: rst asserted in any state forces the reset values immediately (asynchronous). A commit in the same cycle is discarded.
- Commit latency:
  - PSFetchValid rises in the same cycle that PSIMemReady=1 and PSStall=0 (combinational).
  - The new PSPC is visible after that rising edge.
  - Single-cycle memory therefore sustains one commit per clock.
- PSNextPCSrc and PSTarget are sampled only on a commit cycle; they are don't-care otherwise.
- Timeout with PSIMemReady held low and unstalled: PSTimeout rises on the edge ending the MAX_WAIT-th waiting cycle.
- Flag reporting: PSMisaligned and PSTimeout are registered and appear the cycle after the triggering event. Once set, they stay set until rst.

## Test plan
- Reset/release: rst pulse, then PSIMemReady=1, PSNextPCSrc=0 for 4 cycles.
  - PSPC=0 during RESET_HOLD, with no PSFetchValid.
  - Then PSPC goes 0, 4, 8, 12; PSRetired=4.
- Branch taken: at PSPC=8, PSNextPCSrc=1, PSTarget=32'h0000_0101.
  - Next PSPC=32'h100 (bit 0 cleared); PSRetired increments.
- Misaligned: PSNextPCSrc=1, PSTarget=32'h0000_0102.
  - PSPC unchanged, PSMisaligned=1 next cycle.
  - Later PSIMemReady pulses produce no PSFetchValid.
  - rst clears everything.
- Stall priority: PSStall=1 with PSIMemReady=1 for 20 cycles (MAX_WAIT=15).
  - PSPC frozen, PSFetchValid=0, no timeout.
  - Releasing the stall commits on the first cycle.
- Timeout: PSIMemReady=0, PSStall=0 from FETCH.
  - PSTimeout=1 after exactly 15 waiting cycles; state is HALT.
  - Async rst mid-wait at cycle 7 instead yields reset values and no flag.
- Wrap cases:
  - With PSPC forced to 32'hFFFF_FFFC via branch target, a sequential commit gives PSPC=0.
  - With PSRetired preloaded to 32'hFFFF_FFFF by a force, a commit gives 0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-stage handshake bundle between branch unit/imem and pc_sequencer
//
// Signals:
//   PSNextPCSrc   branch decision, 1 = take PSTarget
//   PSTarget      branch/jump target
//   PSStall       hold request, blocks commit
//   PSIMemReady   instruction memory has data for PSPC
//   PSPC          current PC
//   PSPCPlus4     PSPC + 4 (wrapping)
//   PSFetchValid  commit strobe for the instruction at PSPC
//   PSMisaligned  sticky misaligned-target flag
//   PSTimeout     sticky fetch-timeout flag
//   PSRetired     retired-instruction count
// Modports: master = surrounding pipeline, slave = pc_sequencer.

interface pc_sequencer_if;
    logic        PSNextPCSrc;
    logic [31:0] PSTarget;
    logic        PSStall;
    logic        PSIMemReady;
    logic [31:0] PSPC;
    logic [31:0] PSPCPlus4;
    logic        PSFetchValid;
    logic        PSMisaligned;
    logic        PSTimeout;
    logic [31:0] PSRetired;

    modport master (
        output PSNextPCSrc, PSTarget, PSStall, PSIMemReady,
        input  PSPC, PSPCPlus4, PSFetchValid, PSMisaligned, PSTimeout, PSRetired
    );

    modport slave (
        input  PSNextPCSrc, PSTarget, PSStall, PSIMemReady,
        output PSPC, PSPCPlus4, PSFetchValid, PSMisaligned, PSTimeout, PSRetired
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - architectural PC register with imem handshake, halt-on-fault and retire counter
//
// Purpose: holds the PC, advances it to PC+4 or the branch target on every
// committed instruction, halts permanently on a misaligned target or a fetch
// timeout, and counts retired instructions.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pc_sequencer_if.slave (branch decision, stall, imem ready in;
//        PC, PC+4, commit strobe, sticky flags, retired count out)

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    pc_sequencer_if.slave    bus
);

    localparam logic [1:0] S_RESET_HOLD = 2'd0;
    localparam logic [1:0] S_FETCH      = 2'd1;
    localparam logic [1:0] S_HALT       = 2'd2;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        misaligned;
    logic        timeout;
    logic [7:0]  wait_cnt;

    logic        commit;
    logic        bad_target;
    logic        waiting;
    logic        expire;
    logic [7:0]  wait_inc;
    logic [31:0] pc_plus4;
    logic [31:0] target_eff;

    always_comb begin
        commit     = (state == S_FETCH) & bus.PSIMemReady & ~bus.PSStall;
        // jalr semantics: bit 0 of the target is always dropped
        target_eff = bus.PSTarget & 32'hFFFF_FFFE;
        // bit 1 set means the target is not word aligned after clearing bit 0
        bad_target = bus.PSNextPCSrc & bus.PSTarget[1];
        // stall wins over ready, and a stalled cycle never counts as waiting
        waiting    = (state == S_FETCH) & ~bus.PSStall & ~bus.PSIMemReady;
        wait_inc   = wait_cnt + 8'd1;
        expire     = waiting & (wait_inc == MAX_WAIT_C);
        pc_plus4   = pc + 32'd4;
    end

    assign bus.PSPC         = pc;
    assign bus.PSPCPlus4    = pc_plus4;
    assign bus.PSFetchValid = commit;
    assign bus.PSMisaligned = misaligned;
    assign bus.PSTimeout    = timeout;
    assign bus.PSRetired    = retired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RESET_HOLD;
            pc         <= RESET_PC;
            retired    <= 32'd0;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
            wait_cnt   <= 8'd0;
        end else begin
            case (state)
                S_RESET_HOLD: begin
                    state    <= S_FETCH;
                    wait_cnt <= 8'd0;
                end
                S_FETCH: begin
                    if (commit) begin
                        wait_cnt <= 8'd0;
                        if (bad_target) begin
                            misaligned <= 1'b1;
                            state      <= S_HALT;
                        end else begin
                            pc      <= bus.PSNextPCSrc ? target_eff : pc_plus4;
                            retired <= retired + 32'd1;
                        end
                    end else if (bus.PSStall) begin
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (expire) begin
                            timeout <= 1'b1;
                            state   <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    // terminal: everything frozen until rst
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule
